// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency arithmetic pipeline among NREQ requesters.
// Issue is credit-throttled so every in-flight result is guaranteed a response FIFO slot.
module pipe_share_arbiter #(
  parameter int NREQ       = 4,
  parameter int DP_LAT     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*10-1:0]   req_a,
  input  logic [NREQ*10-1:0]   req_b,
  input  logic [NREQ*10-1:0]   req_c,
  output logic                 dp_valid,
  output logic [9:0]           dp_a,
  output logic [9:0]           dp_b,
  output logic [9:0]           dp_c,
  input  logic [13:0]          dp_x,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [13:0]          rsp_data,
  output logic                 busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [13:0]    x;
  } rsp_t;

  logic [NREQ-1:0][9:0]       op_a, op_b, op_c;
  logic [IDW-1:0]             ptr, gnt, idx;
  logic                       gnt_v, can_issue, hs;
  int                         inflight;
  // vld_pipe[0] is the issue register (dp_valid); vld_pipe[DP_LAT] lines up with dp_x
  logic [DP_LAT:0]            vld_pipe;
  logic [DP_LAT:0][IDW-1:0]   id_pipe;
  rsp_t                       mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       push, pop;

  assign op_a = req_a;
  assign op_b = req_b;
  assign op_c = req_c;

  assign dp_valid = vld_pipe[0];
  assign push     = vld_pipe[DP_LAT];
  assign pop      = rsp_valid & rsp_ready;
  assign busy     = (|vld_pipe) | (count != '0);

  always_comb begin
    gnt      = '0;
    gnt_v    = 1'b0;
    idx      = '0;
    inflight = 0;
    // walk backwards so the requester nearest ptr is the last (winning) assignment
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt   = idx;
        gnt_v = 1'b1;
      end
    end
    for (int k = 0; k <= DP_LAT; k++)
      if (vld_pipe[k]) inflight++;
    can_issue = (int'(count) + inflight) < FIFO_DEPTH;
    hs        = gnt_v & can_issue;
    req_ready = '0;
    if (hs) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_c      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      assert (!push || count < CW'(FIFO_DEPTH));
      vld_pipe <= {vld_pipe[DP_LAT-1:0], hs};
      id_pipe  <= {id_pipe[DP_LAT-1:0], gnt};
      dp_a     <= hs ? op_a[gnt] : '0;
      dp_b     <= hs ? op_b[gnt] : '0;
      dp_c     <= hs ? op_c[gnt] : '0;
      if (hs) ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      // head register only sees entries stored before this edge, hence the extra cycle after a push
      rsp_valid <= (count - CW'(pop)) != '0;
      if ((count - CW'(pop)) != '0) begin
        rsp_id   <= mem[rd_ptr + AW'(pop)].id;
        rsp_data <= mem[rd_ptr + AW'(pop)].x;
      end else begin
        rsp_id   <= '0;
        rsp_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: id_pipe[DP_LAT], x: dp_x};
  end

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter with a behavioural 3-stage datapath and issue/response logs.
module tb_pipe_share_arbiter;
  localparam int NREQ = 4, DP_LAT = 3, FIFO_DEPTH = 4, IDW = 2;

  logic              clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*10-1:0] req_a, req_b, req_c;
  logic              dp_valid;
  logic [9:0]        dp_a, dp_b, dp_c;
  logic [13:0]       dp_x;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [13:0]       rsp_data;
  logic              busy;

  int checks = 0, errors = 0;
  int          hs_id[$];
  logic [13:0] hs_x[$];
  int          rq_id[$];
  logic [13:0] rq_x[$];
  logic [13:0] dpx [DP_LAT];

  always #5 clk = ~clk;

  pipe_share_arbiter #(.NREQ(NREQ), .DP_LAT(DP_LAT), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_x(dp_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  function automatic logic [13:0] f(input logic [9:0] a, b, c);
    logic [31:0] t;
    t = 32'(5 * int'(a) + 5 * int'(b) - 4 * int'(c) + 3);
    return t[13:0];
  endfunction

  // external datapath: result appears DP_LAT cycles after the operands are registered
  always_ff @(posedge clk) begin
    dpx[0] <= f(dp_a, dp_b, dp_c);
    for (int k = 1; k < DP_LAT; k++) dpx[k] <= dpx[k-1];
  end
  assign dp_x = dpx[DP_LAT-1];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          hs_id.push_back(i);
          hs_x.push_back(f(req_a[i*10+:10], req_b[i*10+:10], req_c[i*10+:10]));
        end
      if (rsp_valid && rsp_ready) begin
        rq_id.push_back(int'(rsp_id));
        rq_x.push_back(rsp_data);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clearq();
    hs_id.delete(); hs_x.delete(); rq_id.delete(); rq_x.delete();
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    chk({tag, " drain"}, 32'(t < 200), 1);
    @(negedge clk);
    chk({tag, " rsp count"}, rq_id.size(), hs_id.size());
    for (int i = 0; i < hs_id.size(); i++)
      if (i < rq_id.size()) begin
        chk({tag, " rsp id"}, rq_id[i], hs_id[i]);
        chk({tag, " rsp data"}, rq_x[i], hs_x[i]);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, n;
    req_valid = '0; req_a = '0; req_b = '0; req_c = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset dp_valid", dp_valid, 0);
    chk("reset dp_a", dp_a, 0);
    chk("reset rsp_id", rsp_id, 0);
    chk("reset rsp_data", rsp_data, 0);
    rst = 1'b0;

    // all four requesters streaming, round-robin from ptr=0
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*10+:10] = 10'(i + 1); req_b[i*10+:10] = 10'(2 * i); req_c[i*10+:10] = 10'(i);
    end
    req_valid = 4'hf;
    #1 chk("rr first grant", req_ready, 4'b0001);
    repeat (12) @(negedge clk);
    req_valid = '0;
    chk("rr issue count", 32'(hs_id.size() >= 6), 1);
    for (int i = 0; i < hs_id.size(); i++) chk("rr grant order", hs_id[i], i % NREQ);
    drain("rr");

    // single request, latency and value
    clearq();
    req_a[20+:10] = 10'd1; req_b[20+:10] = 10'd2; req_c[20+:10] = 10'd3;
    req_valid = 4'b0100;
    #1 chk("single ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    chk("single dp_valid", dp_valid, 1);
    chk("single dp_a", dp_a, 1);
    chk("single dp_b", dp_b, 2);
    chk("single dp_c", dp_c, 3);
    @(negedge clk);
    chk("idle dp_valid", dp_valid, 0);
    chk("idle dp_c", dp_c, 0);
    e = 1;
    while (!rsp_valid && e < 20) begin @(negedge clk); e++; end
    chk("single latency", e, DP_LAT + 2);
    chk("single rsp_id", rsp_id, 2);
    chk("single rsp_data", rsp_data, 6);
    drain("single");
    chk("single exactly one", rq_id.size(), 1);

    // wrap / negative results; ptr=3 so req0 wins first
    clearq();
    req_a[0+:10] = 10'd0; req_b[0+:10] = 10'd0; req_c[0+:10] = 10'd255;
    req_a[10+:10] = 10'd1023; req_b[10+:10] = 10'd1023; req_c[10+:10] = 10'd0;
    req_valid = 4'b0011;
    #1 chk("wrap grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    drain("wrap");
    if (rq_x.size() >= 2) begin
      chk("wrap negative", rq_x[0], 15367);
      chk("wrap large", rq_x[1], 10233);
    end

    // back-pressure: credits stop issue at FIFO_DEPTH
    clearq();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    for (int i = 0; i < 15; i++) begin
      req_a[0+:10] = 10'(3 * i + 7); req_c[0+:10] = 10'(i);
      @(negedge clk);
    end
    #1;
    chk("bp handshakes", hs_id.size(), FIFO_DEPTH);
    chk("bp ready low", req_ready, 0);
    chk("bp rsp_valid", rsp_valid, 1);
    chk("bp busy", busy, 1);
    rsp_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("bp resumed", 32'(hs_id.size() > FIFO_DEPTH), 1);
    req_valid = '0;
    drain("bp");

    // reset with work both in flight and queued
    clearq();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (5) @(negedge clk);
    req_valid = '0;
    chk("pre-reset busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst dp_valid", dp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    rsp_ready = 1'b1;
    n = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid || busy) n++; end
    chk("rst no stale", n, 0);
    chk("rst no rsp", rq_id.size(), 0);
    clearq();
    req_valid = 4'hf;
    #1 chk("rst ptr zero", req_ready, 4'b0001);
    req_valid = 4'b0010;
    #1 chk("fair setup", req_ready, 4'b0010);
    @(negedge clk);

    // fairness between req3 and req1 starting from ptr=2, consumer toggling
    req_valid = 4'b1010;
    #1 chk("fair first", req_ready, 4'b1000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rsp_ready = ~rsp_ready;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain("fair");
    chk("fair count", 32'(hs_id.size() >= 4), 1);
    if (hs_id.size() >= 4) begin
      chk("fair g1", hs_id[1], 3);
      chk("fair g2", hs_id[2], 1);
      chk("fair g3", hs_id[3], 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
